// File: rtl/gcd_csr_pkg.sv
// gcd_csr_pkg
// Shared constants for the multi-channel GCD APB control/status block:
// global register offsets, per-channel window layout (base, stride and
// offsets inside a window), CTRL field positions and the default ID word.
package gcd_csr_pkg;

    // Global register byte offsets
    localparam logic [11:0] ADDR_ID         = 12'h000;
    localparam logic [11:0] ADDR_IRQ_EN     = 12'h004;
    localparam logic [11:0] ADDR_IRQ_STATUS = 12'h008;
    localparam logic [11:0] ADDR_RUN_STATUS = 12'h00C;
    localparam logic [11:0] ADDR_DONE_COUNT = 12'h010;

    // Channel windows: channel c lives at CH_BASE + c*CH_STRIDE
    localparam logic [11:0] CH_BASE   = 12'h100;
    localparam logic [11:0] CH_STRIDE = 12'h040;
    localparam int          CH_SHIFT  = 6;        // log2(CH_STRIDE)

    // Offsets inside a channel window
    localparam logic [5:0] CH_OFF_CTRL = 6'h00;
    localparam logic [5:0] CH_OFF_CAP  = 6'h04;
    localparam logic [5:0] CH_OFF_DBG  = 6'h08;   // debug word w at +0x08 + 4w

    // CTRL register bit positions
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_OPCODE_LSB = 1;
    localparam int CTRL_OPCODE_W   = 12;
    localparam int CTRL_DEBUG_BIT  = 13;
    localparam int CTRL_CONST_BIT  = 14;
    localparam int CTRL_W          = 15;

    localparam logic [31:0] DEFAULT_ID = 32'h5A5A_0002;

endpackage

// File: rtl/gcd_csr_channel.sv
// gcd_csr_channel
// Per-channel state of the GCD control block: CTRL fields, one-cycle START
// pulse, RUN flag, this channel's IRQ_STATUS bit and the done-time capture
// of the cycle counter.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   ctrl_wr_i           decoded APB write to this channel's CTRL
//   wdata_i             low CTRL_W bits of PWDATA
//   irq_clr_i           W1C clear request for this channel's status bit
//   done_pulse_i        completion pulse from the GCD core
//   cycle_count_i       live cycle count of the GCD core
//   constant_time_o, debug_mode_o, opcode_o, start_pulse_o   core controls
//   run_o               channel busy
//   irq_status_o        sticky completion flag
//   cap_count_o         cycle count captured at the accepted done
//   accepted_done_o     done_pulse_i qualified by RUN
//   lock_err_o          CTRL write attempted while running (write dropped)
module gcd_csr_channel
    import gcd_csr_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ctrl_wr_i,
    input  logic [CTRL_W-1:0]        wdata_i,
    input  logic                     irq_clr_i,
    input  logic                     done_pulse_i,
    input  logic [CNT_W-1:0]         cycle_count_i,
    output logic                     constant_time_o,
    output logic                     debug_mode_o,
    output logic [CTRL_OPCODE_W-1:0] opcode_o,
    output logic                     start_pulse_o,
    output logic                     run_o,
    output logic                     irq_status_o,
    output logic [CNT_W-1:0]         cap_count_o,
    output logic                     accepted_done_o,
    output logic                     lock_err_o
);

    logic                     const_q, const_d;
    logic                     debug_q, debug_d;
    logic [CTRL_OPCODE_W-1:0] opcode_q, opcode_d;
    logic                     start_q, start_d;
    logic                     run_q, run_d;
    logic                     irq_q, irq_d;
    logic [CNT_W-1:0]         cap_q, cap_d;
    logic                     ctrl_accept;

    // While running, CTRL is locked: the write is dropped and flagged.
    assign ctrl_accept     = ctrl_wr_i & ~run_q;
    assign lock_err_o      = ctrl_wr_i & run_q;
    assign accepted_done_o = done_pulse_i & run_q;

    always_comb begin
        const_d  = const_q;
        debug_d  = debug_q;
        opcode_d = opcode_q;
        start_d  = 1'b0;
        run_d    = run_q;
        cap_d    = cap_q;

        if (ctrl_accept) begin
            const_d  = wdata_i[CTRL_CONST_BIT];
            debug_d  = wdata_i[CTRL_DEBUG_BIT];
            opcode_d = wdata_i[CTRL_OPCODE_LSB +: CTRL_OPCODE_W];
            start_d  = wdata_i[CTRL_START_BIT];
        end

        // Start needs RUN=0 and done needs RUN=1, so the two never collide.
        if (accepted_done_o) begin
            run_d = 1'b0;
            cap_d = cycle_count_i;
        end else if (start_d) begin
            run_d = 1'b1;
        end

        // A set arriving with a clear in the same cycle wins.
        irq_d = (irq_q & ~irq_clr_i) | accepted_done_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            const_q  <= 1'b0;
            debug_q  <= 1'b0;
            opcode_q <= '0;
            start_q  <= 1'b0;
            run_q    <= 1'b0;
            irq_q    <= 1'b0;
            cap_q    <= '0;
        end else begin
            const_q  <= const_d;
            debug_q  <= debug_d;
            opcode_q <= opcode_d;
            start_q  <= start_d;
            run_q    <= run_d;
            irq_q    <= irq_d;
            cap_q    <= cap_d;
        end
    end

    assign constant_time_o = const_q;
    assign debug_mode_o    = debug_q;
    assign opcode_o        = opcode_q;
    assign start_pulse_o   = start_q;
    assign run_o           = run_q;
    assign irq_status_o    = irq_q;
    assign cap_count_o     = cap_q;

endmodule

// File: rtl/gcd_apb_csr_multi.sv
// gcd_apb_csr_multi
// APB3 control/status block for NUM_CH independent GCD cores. Holds the
// address decode, read mux, IRQ enable mask, saturating accepted-done
// counter and the registered PRDATA/PSLVERR; per-channel state lives in
// gcd_csr_channel instances.
//
// Ports:
//   CLK, RESET                 clock, asynchronous active-high reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA   APB request (PADDR[11:2] decoded)
//   PREADY (tied 1), PSLVERR, PRDATA   APB response, valid in access phase
//   CONSTANT_TIME, DEBUG_MODE, START_PULSE, OPCODE   per-channel controls
//   DONE_PULSE, CYCLE_COUNT, DEBUG_DATA              per-channel status in
//   IRQ                        |(IRQ_STATUS & IRQ_EN)
module gcd_apb_csr_multi
    import gcd_csr_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 12,
    parameter int          DBG_WORDS = 4,
    parameter logic [31:0] ID_VALUE  = DEFAULT_ID
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [31:0]                   PADDR,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [31:0]                   PWDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    output logic [31:0]                   PRDATA,
    output logic [NUM_CH-1:0]             CONSTANT_TIME,
    output logic [NUM_CH-1:0]             DEBUG_MODE,
    output logic [NUM_CH-1:0]             START_PULSE,
    output logic [NUM_CH*12-1:0]          OPCODE,
    input  logic [NUM_CH-1:0]             DONE_PULSE,
    input  logic [NUM_CH*CNT_W-1:0]       CYCLE_COUNT,
    input  logic [NUM_CH*DBG_WORDS*32-1:0] DEBUG_DATA,
    output logic                          IRQ
);

    logic              setup, wr_en, rd_en;
    logic [11:0]       addr_b, rel;
    logic              ch_space;
    logic [5:0]        ch_idx, ch_off, dbg_rel;
    logic [3:0]        dword;
    logic              ch_valid, dbg_hit;

    logic              dec_err;
    logic [31:0]       rd_val;
    logic              sel_irq_en, sel_irq_st, sel_dcnt;
    logic [NUM_CH-1:0] ctrl_sel, ctrl_wr, irq_clr;

    logic [NUM_CH-1:0]       run, irq_status, accepted, lock_err;
    logic [NUM_CH*CNT_W-1:0] cap_flat;

    logic [NUM_CH-1:0] irq_en_q, irq_en_d;
    logic [31:0]       dcnt_q, dcnt_d;
    logic [31:0]       prdata_q, prdata_d;
    logic              pslverr_q, pslverr_d;
    logic [3:0]        pop;
    logic [31:0]       dcnt_base;
    logic [32:0]       dcnt_sum;

    logic              unused_ok;
    assign unused_ok = ^{PADDR[31:12], PADDR[1:0], PWDATA[31:CTRL_W]};

    assign setup = PSEL & ~PENABLE;
    assign wr_en = setup & PWRITE;
    assign rd_en = setup & ~PWRITE;

    // Channel window geometry
    assign addr_b   = {PADDR[11:2], 2'b00};
    assign ch_space = (addr_b >= CH_BASE);
    assign rel      = addr_b - CH_BASE;
    assign ch_idx   = rel[11:CH_SHIFT];
    assign ch_off   = rel[CH_SHIFT-1:0];
    assign ch_valid = ch_space && (ch_idx < 6'(NUM_CH));
    assign dbg_rel  = ch_off - CH_OFF_DBG;
    assign dword    = dbg_rel[5:2];
    assign dbg_hit  = (ch_off >= CH_OFF_DBG) && (dword < 4'(DBG_WORDS));

    // Decode + read mux. dec_err covers unmapped and RO-write cases; the
    // locked-CTRL case comes back from the channels as lock_err.
    always_comb begin
        dec_err    = 1'b0;
        rd_val     = '0;
        sel_irq_en = 1'b0;
        sel_irq_st = 1'b0;
        sel_dcnt   = 1'b0;
        ctrl_sel   = '0;

        if (!ch_space) begin
            case (addr_b)
                ADDR_ID: begin
                    rd_val  = ID_VALUE;
                    dec_err = PWRITE;
                end
                ADDR_IRQ_EN: begin
                    rd_val     = 32'(irq_en_q);
                    sel_irq_en = 1'b1;
                end
                ADDR_IRQ_STATUS: begin
                    rd_val     = 32'(irq_status);
                    sel_irq_st = 1'b1;
                end
                ADDR_RUN_STATUS: begin
                    rd_val  = 32'(run);
                    dec_err = PWRITE;
                end
                ADDR_DONE_COUNT: begin
                    rd_val   = dcnt_q;
                    sel_dcnt = 1'b1;
                end
                default: dec_err = 1'b1;
            endcase
        end else if (!ch_valid) begin
            dec_err = 1'b1;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == 6'(c)) begin
                    if (ch_off == CH_OFF_CTRL) begin
                        rd_val      = {17'd0, CONSTANT_TIME[c], DEBUG_MODE[c],
                                       OPCODE[12*c +: 12], 1'b0};
                        ctrl_sel[c] = 1'b1;
                    end else if (ch_off == CH_OFF_CAP) begin
                        rd_val[CNT_W-1:0] = cap_flat[c*CNT_W +: CNT_W];
                        dec_err           = PWRITE;
                    end else if (dbg_hit) begin
                        for (int w = 0; w < DBG_WORDS; w++) begin
                            if (dword == 4'(w))
                                rd_val = DEBUG_DATA[(c*DBG_WORDS + w)*32 +: 32];
                        end
                        dec_err = PWRITE;
                    end else begin
                        dec_err = 1'b1;
                    end
                end
            end
        end

        // Unmapped reads return zero.
        if (dec_err)
            rd_val = '0;
    end

    assign ctrl_wr = ctrl_sel & {NUM_CH{wr_en}};
    assign irq_clr = (wr_en && sel_irq_st) ? PWDATA[NUM_CH-1:0] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            gcd_csr_channel #(
                .CNT_W(CNT_W)
            ) u_ch (
                .clk_i           (CLK),
                .rst_i           (RESET),
                .ctrl_wr_i       (ctrl_wr[gi]),
                .wdata_i         (PWDATA[CTRL_W-1:0]),
                .irq_clr_i       (irq_clr[gi]),
                .done_pulse_i    (DONE_PULSE[gi]),
                .cycle_count_i   (CYCLE_COUNT[gi*CNT_W +: CNT_W]),
                .constant_time_o (CONSTANT_TIME[gi]),
                .debug_mode_o    (DEBUG_MODE[gi]),
                .opcode_o        (OPCODE[12*gi +: 12]),
                .start_pulse_o   (START_PULSE[gi]),
                .run_o           (run[gi]),
                .irq_status_o    (irq_status[gi]),
                .cap_count_o     (cap_flat[gi*CNT_W +: CNT_W]),
                .accepted_done_o (accepted[gi]),
                .lock_err_o      (lock_err[gi])
            );
        end
    endgenerate

    // Accepted-done counter; a clear in the same cycle keeps this cycle's
    // increments, and the sum saturates instead of wrapping.
    always_comb begin
        pop = '0;
        for (int c = 0; c < NUM_CH; c++)
            pop = pop + 4'(accepted[c]);
        dcnt_base = (wr_en && sel_dcnt) ? 32'd0 : dcnt_q;
        dcnt_sum  = {1'b0, dcnt_base} + 33'(pop);
        dcnt_d    = dcnt_sum[32] ? 32'hFFFF_FFFF : dcnt_sum[31:0];
    end

    always_comb begin
        irq_en_d  = (wr_en && sel_irq_en) ? PWDATA[NUM_CH-1:0] : irq_en_q;
        prdata_d  = rd_en ? rd_val : prdata_q;
        pslverr_d = setup & (dec_err | (|lock_err));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            irq_en_q  <= '0;
            dcnt_q    <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            irq_en_q  <= irq_en_d;
            dcnt_q    <= dcnt_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign PREADY  = 1'b1;
    assign PRDATA  = prdata_q;
    assign PSLVERR = pslverr_q;
    assign IRQ     = |(irq_status & irq_en_q);

endmodule

// File: tb/tb_gcd_apb_csr_multi.sv
module tb_gcd_apb_csr_multi;

    localparam int NUM_CH    = 4;
    localparam int CNT_W     = 12;
    localparam int DBG_WORDS = 4;

    logic                          CLK = 1'b0;
    logic                          RESET;
    logic [31:0]                   PADDR;
    logic                          PSEL, PENABLE, PWRITE;
    logic [31:0]                   PWDATA;
    logic                          PREADY, PSLVERR;
    logic [31:0]                   PRDATA;
    logic [NUM_CH-1:0]             CONSTANT_TIME, DEBUG_MODE, START_PULSE;
    logic [NUM_CH*12-1:0]          OPCODE;
    logic [NUM_CH-1:0]             DONE_PULSE;
    logic [NUM_CH*CNT_W-1:0]       CYCLE_COUNT;
    logic [NUM_CH*DBG_WORDS*32-1:0] DEBUG_DATA;
    logic                          IRQ;

    gcd_apb_csr_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DBG_WORDS(DBG_WORDS), .ID_VALUE(32'h5A5A_0002)
    ) dut (
        .CLK(CLK), .RESET(RESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .PRDATA(PRDATA), .CONSTANT_TIME(CONSTANT_TIME), .DEBUG_MODE(DEBUG_MODE),
        .START_PULSE(START_PULSE), .OPCODE(OPCODE), .DONE_PULSE(DONE_PULSE),
        .CYCLE_COUNT(CYCLE_COUNT), .DEBUG_DATA(DEBUG_DATA), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Scoreboard: {expected PSLVERR, expected PRDATA} pushed at setup,
    // popped and compared in the access phase.
    logic [32:0] exp_q[$];
    string       tag_q[$];
    logic        rd_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic sb_compare();
        logic [32:0] e;
        string       t;
        logic        is_rd;
        e     = exp_q.pop_front();
        t     = tag_q.pop_front();
        is_rd = rd_q.pop_front();
        $display("txn %-10s %s addr=%08h pslverr=%0d prdata=%08h", t, is_rd ? "RD" : "WR",
                 PADDR, PSLVERR, PRDATA);
        check({t, ".err"}, 32'(PSLVERR), 32'(e[32]));
        if (is_rd)
            check({t, ".data"}, PRDATA, e[31:0]);
    endtask

    // Returns in the access phase (T+1) with PENABLE high.
    task automatic apb_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic exp_err, input logic [NUM_CH-1:0] done);
        @(negedge CLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        DONE_PULSE = done;
        exp_q.push_back({exp_err, 32'h0}); tag_q.push_back(tag); rd_q.push_back(1'b0);
        @(negedge CLK);
        DONE_PULSE = '0;
        sb_compare();
        PENABLE = 1'b1;
    endtask

    task automatic apb_read(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
        @(negedge CLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        exp_q.push_back({exp_err, exp_data}); tag_q.push_back(tag); rd_q.push_back(1'b1);
        @(negedge CLK);
        sb_compare();
        PENABLE = 1'b1;
    endtask

    task automatic idle();
        @(negedge CLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Returns at D+1.
    task automatic pulse_done(input logic [NUM_CH-1:0] vec);
        @(negedge CLK);
        PSEL = 1'b0; PENABLE = 1'b0; DONE_PULSE = vec;
        @(negedge CLK);
        DONE_PULSE = '0;
    endtask

    initial begin
        RESET = 1'b1; PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PWDATA = '0; DONE_PULSE = '0; CYCLE_COUNT = '0;
        for (int k = 0; k < NUM_CH*DBG_WORDS; k++)
            DEBUG_DATA[k*32 +: 32] = 32'hD000_0000 + 32'(k);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        // Reset state
        check("rst.start", 32'(START_PULSE), 32'h0);
        check("rst.ct", 32'(CONSTANT_TIME), 32'h0);
        check("rst.dm", 32'(DEBUG_MODE), 32'h0);
        check("rst.opcode", OPCODE[31:0], 32'h0);
        check("rst.irq", 32'(IRQ), 32'h0);
        check("rst.prdata", PRDATA, 32'h0);
        check("rst.pslverr", 32'(PSLVERR), 32'h0);
        check("rst.pready", 32'(PREADY), 32'h1);

        apb_read("id", 32'h000, 32'h5A5A_0002, 1'b0);
        apb_read("run0", 32'h00C, 32'h0, 1'b0);

        // Channel 0 start with fields
        apb_write("ch0.ctrl", 32'h100, 32'h0000_6003, 1'b0, '0);
        check("ch0.start_hi", 32'(START_PULSE), 32'h1);
        check("ch0.opcode", 32'(OPCODE[11:0]), 32'h001);
        check("ch0.dm", 32'(DEBUG_MODE), 32'h1);
        check("ch0.ct", 32'(CONSTANT_TIME), 32'h1);
        idle();
        check("ch0.start_lo", 32'(START_PULSE), 32'h0);
        apb_read("run1", 32'h00C, 32'h1, 1'b0);
        apb_read("ch0.rd", 32'h100, 32'h0000_6002, 1'b0);

        // Locked rewrite
        apb_write("ch0.lock", 32'h100, 32'h0000_0005, 1'b1, '0);
        check("lock.start", 32'(START_PULSE), 32'h0);
        check("lock.opcode", 32'(OPCODE[11:0]), 32'h001);
        apb_read("lock.rd", 32'h100, 32'h0000_6002, 1'b0);

        // Channel 1 run/done/capture/IRQ
        apb_write("ch1.ctrl", 32'h140, 32'h1, 1'b0, '0);
        CYCLE_COUNT[1*CNT_W +: CNT_W] = 12'h02A;
        pulse_done(4'b0010);
        check("ch1.irq_masked", 32'(IRQ), 32'h0);
        apb_read("ch1.cap", 32'h144, 32'h0000_002A, 1'b0);
        apb_read("irqst2", 32'h008, 32'h2, 1'b0);
        apb_read("run.ch0", 32'h00C, 32'h1, 1'b0);
        apb_read("dcnt1", 32'h010, 32'h1, 1'b0);
        apb_write("irqen", 32'h004, 32'h2, 1'b0, '0);
        check("irq.on", 32'(IRQ), 32'h1);
        apb_write("w1c2", 32'h008, 32'h2, 1'b0, '0);
        check("irq.off", 32'(IRQ), 32'h0);
        apb_read("irqst0", 32'h008, 32'h0, 1'b0);

        // Set beats clear on the same cycle
        apb_write("ch2.ctrl", 32'h180, 32'h1, 1'b0, '0);
        apb_write("w1c.race", 32'h008, 32'h4, 1'b0, 4'b0100);
        apb_read("race.st", 32'h008, 32'h4, 1'b0);
        apb_read("dcnt2", 32'h010, 32'h2, 1'b0);

        // All four done while DONE_COUNT is cleared
        apb_write("ch1.go", 32'h140, 32'h1, 1'b0, '0);
        apb_write("ch2.go", 32'h180, 32'h1, 1'b0, '0);
        apb_write("ch3.go", 32'h1C0, 32'h1, 1'b0, '0);
        CYCLE_COUNT = {12'hC03, 12'hB02, 12'hA01, 12'h9FF};
        apb_write("dcnt.clr", 32'h010, 32'hDEAD_BEEF, 1'b0, 4'b1111);
        apb_read("dcnt4", 32'h010, 32'h4, 1'b0);
        apb_read("run.all0", 32'h00C, 32'h0, 1'b0);
        apb_read("irqstF", 32'h008, 32'hF, 1'b0);
        check("irq.all", 32'(IRQ), 32'h1);
        apb_read("ch0.cap", 32'h104, 32'h0000_09FF, 1'b0);
        apb_read("ch3.cap", 32'h1C4, 32'h0000_0C03, 1'b0);

        // Spurious done on an idle channel
        apb_write("w1c.all", 32'h008, 32'hF, 1'b0, '0);
        CYCLE_COUNT[0 +: CNT_W] = 12'h123;
        pulse_done(4'b0001);
        check("spur.irq", 32'(IRQ), 32'h0);
        apb_read("spur.st", 32'h008, 32'h0, 1'b0);
        apb_read("spur.dcnt", 32'h010, 32'h4, 1'b0);
        apb_read("spur.cap", 32'h104, 32'h0000_09FF, 1'b0);

        // Debug words and error responses
        apb_read("dbg.c0w0", 32'h108, 32'hD000_0000, 1'b0);
        apb_read("dbg.c3w3", 32'h1D4, 32'hD000_000F, 1'b0);
        apb_read("dbg.w4", 32'h118, 32'h0, 1'b1);
        apb_read("id2", 32'h000, 32'h5A5A_0002, 1'b0);
        apb_read("ch4", 32'h200, 32'h0, 1'b1);
        apb_write("ro.run", 32'h00C, 32'hFFFF_FFFF, 1'b1, '0);
        apb_read("ro.run.rd", 32'h00C, 32'h0, 1'b0);
        apb_write("ro.cap", 32'h104, 32'h0, 1'b1, '0);
        apb_read("ro.cap.rd", 32'h104, 32'h0000_09FF, 1'b0);
        apb_write("ro.id", 32'h000, 32'h1, 1'b1, '0);
        apb_write("unmap", 32'h014, 32'h1, 1'b1, '0);
        apb_read("irqen.rd", 32'h004, 32'h2, 1'b0);
        idle();
        check("prdata.hold", PRDATA, 32'h2);
        check("pslverr.idle", 32'(PSLVERR), 32'h0);

        // Asynchronous reset mid-operation
        apb_write("ch0.rst", 32'h100, 32'h0000_6003, 1'b0, '0);
        #2 RESET = 1'b1;
        #1;
        check("arst.start", 32'(START_PULSE), 32'h0);
        check("arst.ct", 32'(CONSTANT_TIME), 32'h0);
        check("arst.prdata", PRDATA, 32'h0);
        idle();
        RESET = 1'b0;
        apb_read("arst.run", 32'h00C, 32'h0, 1'b0);
        apb_read("arst.dcnt", 32'h010, 32'h0, 1'b0);
        apb_read("arst.irqen", 32'h004, 32'h0, 1'b0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gcd_apb_csr_multi.md
# gcd_apb_csr_multi

Parametrised APB3 control/status block for a GCD wrapper hosting `NUM_CH` independent GCD cores. It provides per-channel control, a busy interlock, and done-time cycle-count capture. It also holds a global W1C interrupt status with enable mask, an accepted-done counter, and a PSLVERR error response. It sits between the APB fabric and the channel array, replacing the single-channel register file.

## Interface
- `NUM_CH`, 4, number of GCD channels (1..8)
- `CNT_W`, 12, cycle-count width per channel (1..32)
- `DBG_WORDS`, 4, 32-bit debug words per channel (1..12)
- `ID_VALUE`, 32'h5A5A_0002, ID register value
- Clock/reset: one clock; reset is asynchronous and active-high.
- `CLK` in 1: sole clock
- `RESET` in 1: asynchronous, active-high reset
- `PADDR` in 32: APB address; `[11:2]` decoded, `[1:0]` ignored
- `PSEL`, `PENABLE`, `PWRITE` in 1 each: APB control
- `PWDATA` in 32: write data
- `PREADY` out 1: tied 1
- `PSLVERR` out 1: registered error, valid in access phase
- `PRDATA` out 32: registered read data
- `CONSTANT_TIME`, `DEBUG_MODE`, `START_PULSE` out NUM_CH each: per-channel control
- `OPCODE` out NUM_CH*12: channel c at `[12c+11:12c]`
- `DONE_PULSE` in NUM_CH: per-channel completion pulse
- `CYCLE_COUNT` in NUM_CH*CNT_W: live per-channel counts
- `DEBUG_DATA` in NUM_CH*DBG_WORDS*32: word w of channel c at index c*DBG_WORDS+w
- `IRQ` out 1: `|(IRQ_STATUS & IRQ_EN)`

## Operation
- Access decode happens in the setup phase: `PSEL & ~PENABLE`. Write enable is that term & `PWRITE`; read enable is that term & `~PWRITE`.
- Global map:
  - 0x000 ID (RO)
  - 0x004 IRQ_EN (RW, `[NUM_CH-1:0]`)
  - 0x008 IRQ_STATUS (W1C)
  - 0x00C RUN_STATUS (RO)
  - 0x010 DONE_COUNT (RO value; any write clears it)
- Channel c map, base 0x100 + c*0x40:
  - +0x00 CTRL: CONSTANT_TIME[14], DEBUG_MODE[13], OPCODE[12:1], START[0]; START reads 0.
  - +0x04 CAP_COUNT (RO, zero-extended).
  - +0x08 + 4w: DEBUG word w (RO, live).
- CTRL write with RUN[c]=0: fields update. If `PWDATA[0]`=1, START_PULSE[c] asserts for exactly one cycle and RUN[c] sets.
- CTRL write with RUN[c]=1: the whole write is ignored (fields locked) and PSLVERR=1.
- Accepted done is DONE_PULSE[c] & RUN[c]. On an accepted done:
  - RUN[c] clears.
  - IRQ_STATUS[c] sets.
  - CAP_COUNT[c] captures the CYCLE_COUNT slice.
- DONE_PULSE with RUN=0 is ignored entirely: no IRQ, no capture, no count.
- IRQ_STATUS clear: writing 1 clears a bit. If set and clear hit the same bit in the same cycle, set wins.
- DONE_COUNT behaviour:
  - Each cycle it adds the popcount of accepted dones, saturating at 0xFFFF_FFFF.
  - A clear in the same cycle as increments yields the popcount, not 0.
- PSLVERR=1 cases:
  - Unmapped address (including channel ≥ NUM_CH and debug word ≥ DBG_WORDS); such reads return 0.
  - Write to an RO register other than DONE_COUNT.
  - Locked CTRL write.
- Error writes have no side effect.
- PRDATA updates only on read-enable cycles and holds otherwise. PSLVERR is 0 on every other access.

## Timing
- Reset values: all outputs 0; PRDATA=0; all internal registers 0.
- Reads: setup-phase cycle T; PRDATA/PSLVERR valid at T+1 (access phase); zero wait states.
- Writes: register updated at the edge ending cycle T; value visible at T+1.
- START_PULSE[c] is high during T+1 only; RUN[c]=1 from T+1.
- DONE_PULSE in cycle D: RUN clear, IRQ_STATUS set, and capture are visible at D+1. IRQ follows combinationally from registers, so it is high in D+1 if enabled.
- A new start is legal from the first cycle RUN=0, i.e. setup at D+1.
- Reset asserted mid-operation clears everything immediately (asynchronously). Channels must tolerate a lost START.

## Structure
- Package `gcd_csr_pkg`: address offsets (global and per-channel), channel stride 0x40, channel base 0x100, CTRL bit positions, default ID.
- Sub-module `gcd_csr_channel`, generated NUM_CH times. It holds CTRL, START pulse, RUN, IRQ_STATUS bit, and CAP_COUNT. It outputs `accepted_done` and a `lock_err` flag.
- Top level holds decode, read mux, DONE_COUNT (popcount adder), IRQ_EN, and the PRDATA/PSLVERR registers.

## Test plan
- Reset, then read 0x000 → 0x5A5A_0002; read 0x00C → 0; all outputs 0.
- Write 0x100 = 0x0000_6003 → ch0: OPCODE=0x001, DEBUG_MODE=1, CONSTANT_TIME=1; START_PULSE[0] one cycle; RUN_STATUS=0x1. Rewrite 0x100 while running → PSLVERR=1, fields unchanged.
- Ch1 started; CYCLE_COUNT[1]=0x2A; DONE_PULSE[1] → CAP 0x144 reads 0x2A; IRQ_STATUS=0x2; IRQ=1 only after IRQ_EN=0x2. W1C 0x2 → IRQ=0.
- W1C on bit 2 in the same cycle as accepted DONE_PULSE[2] → bit stays 1.
- All 4 channels done in one cycle while DONE_COUNT is cleared → DONE_COUNT=4. Spurious DONE on idle channel → no change.
- Read 0x200 with NUM_CH=4, and write to 0x00C → PSLVERR=1, PRDATA=0, no state change.
